heavyhash_xor_packer: RTL and testbench
=======================================

Name: heavyhash_xor_packer

Overview:
- Downstream of the matrix multiplier datapath/controller in the oBTC miner.
- Consumes the 64 row dot-product sums of one heavyhash multiply, delivered LANES rows per beat.
- Reduces each sum to a nibble (sum >> SHIFT, 4 bits) and packs the 64 nibbles into a 256-bit vector.
- XORs that vector with the original 256-bit hash input, then writes the result into the hashout FIFO, respecting FIFO full.

Parameters:
- LANES, 16, row sums delivered per product beat.
- SUM_W, 14, width of one row sum (max 64*15*15 = 14400 < 2^14).
- SHIFT, 10, right shift applied to each sum before truncation to 4 bits.
- HASH_W, 256, hash width; rows = HASH_W/4 = 64.
- BEATS, HASH_W/(4*LANES) = 4, derived; product beats per hash.

Ports:
- clk  in  1  global clock.
- rst  in  1  global reset, asynchronous, active-high.
- hash_in_valid  in  1  original hash word available.
- hash_in_data  in  HASH_W  original hash; nibble r at bits [4r+3:4r].
- hash_in_ready  out  1  hash accepted on valid&&ready.
- prod_valid  in  1  product beat available.
- prod_data  in  LANES*SUM_W  lane l sum at bits [l*SUM_W+SUM_W-1 : l*SUM_W].
- prod_ready  out  1  beat accepted on valid&&ready.
- out_full  in  1  hashout FIFO full.
- out_we  out  1  hashout FIFO write strobe, one cycle per result.
- out_data  out  HASH_W  packed XOR result; valid when out_we=1.
- busy  out  1  state != IDLE.
- words_out  out  32  count of results written; wraps at 2^32.

Behaviour:
- Reset (async, any state): state=IDLE, beat_cnt=0, hash_reg=0, nib_reg=0, out_we=0, out_data=0, words_out=0. A partially collected hash is discarded; no partial write is ever emitted.
- FSM states: IDLE, COLLECT, EMIT.
- IDLE:
  - hash_in_ready=1, prod_ready=0.
  - On hash_in_valid: capture hash_reg, clear beat_cnt, go to COLLECT.
- COLLECT:
  - prod_ready=1, hash_in_ready=0.
  - On each accepted beat, lane l writes nibble index beat_cnt*LANES+l = prod_sum_l[SHIFT+3:SHIFT]. Bits above SHIFT+3 are ignored (no saturation), then beat_cnt increments.
  - On acceptance with beat_cnt==BEATS-1: go to EMIT.
  - prod_valid low: hold state and beat_cnt indefinitely.
- EMIT:
  - Both readies are 0.
  - If out_full=0: next edge registers out_we=1, out_data = {nib_reg with last beat} ^ hash_reg, increments words_out, and returns to IDLE.
  - If out_full=1: stay in EMIT, out_we=0, results held. There is no drop and no timeout.
- out_we is a registered single-cycle pulse; it deasserts the cycle after assertion. out_data holds its value until the next write.
- Latency: last beat accepted at edge N → EMIT during cycle N. With out_full=0, out_we is high in the cycle after edge N+1. Hence 2 edges from last beat to write.
- Back-to-back: in the cycle out_we is high the FSM is already in IDLE, so hash_in_ready=1 and the next hash may be accepted the same cycle. Sustained throughput is one result per BEATS+2 cycles.
- prod_valid in IDLE/EMIT and hash_in_valid in COLLECT/EMIT are ignored; nothing is consumed.
- out_full is sampled only in EMIT. Write decisions are made on the registered path, so the FIFO sees out_we only when it reported not full the previous cycle.

Test Plan:
- Reset mid-COLLECT after 2 beats → all outputs 0 immediately (async), busy=0. Next hash with 4 beats produces a result built from the new beats only.
- Hash=all 0, beats where every sum=0x0400 → out_data = all nibbles 1 (256'h1111…1), out_we exactly one cycle, 2 edges after the last beat, words_out=1.
- Hash=256'hFFFF…F, all sums=0x3C00 (nibble 15) → out_data=0. Also check a sum of 0x3FFF (nibble 15) and 0x03FF (nibble 0) in lanes 0/1 of beat 3 land at nibble indices 48/49.
- Hold out_full=1 for 10 cycles in EMIT → no out_we, prod_ready=0 and hash_in_ready=0 throughout. Releasing out_full → one write with unchanged data.
- Insert prod_valid gaps (valid 1,0,0,1,1,0,1) → exactly 4 beats consumed, correct nibble placement, single write.
- Three hashes back-to-back with continuous valids → 3 writes spaced BEATS+2=6 cycles, words_out=3. Preset words_out to 32'hFFFFFFFF → wraps to 0.

Source files
------------

// File: rtl/heavyhash_xor_packer.sv
// Packs the 64 row-sum nibbles of one heavyhash multiply, XORs them with the
// original hash and writes the result into the hashout FIFO.
module heavyhash_xor_packer #(
  parameter int unsigned LANES  = 16,
  parameter int unsigned SUM_W  = 14,
  parameter int unsigned SHIFT  = 10,
  parameter int unsigned HASH_W = 256,
  parameter int unsigned BEATS  = HASH_W / (4 * LANES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hash_in_valid,
  input  logic [HASH_W-1:0]      hash_in_data,
  output logic                   hash_in_ready,
  input  logic                   prod_valid,
  input  logic [LANES*SUM_W-1:0] prod_data,
  output logic                   prod_ready,
  input  logic                   out_full,
  output logic                   out_we,
  output logic [HASH_W-1:0]      out_data,
  output logic                   busy,
  output logic [31:0]            words_out
);

  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    EMIT
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [HASH_W-1:0] hash_q, hash_d;
  logic [HASH_W-1:0] nib_q, nib_d;
  logic              out_we_q, out_we_d;
  logic [HASH_W-1:0] out_data_q, out_data_d;
  logic [31:0]       words_out_q, words_out_d;

  // Only bits [SHIFT+3:SHIFT] of each lane are consumed.
  logic unused_prod_bits;
  assign unused_prod_bits = ^prod_data;

  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    hash_d        = hash_q;
    nib_d         = nib_q;
    out_we_d      = 1'b0;
    out_data_d    = out_data_q;
    words_out_d   = words_out_q;
    hash_in_ready = 1'b0;
    prod_ready    = 1'b0;

    case (state_q)
      IDLE: begin
        hash_in_ready = 1'b1;
        if (hash_in_valid) begin
          hash_d     = hash_in_data;
          beat_cnt_d = '0;
          state_d    = COLLECT;
        end
      end

      COLLECT: begin
        prod_ready = 1'b1;
        if (prod_valid) begin
          // Beat select by compare keeps every nibble slice at a constant offset.
          for (int unsigned b = 0; b < BEATS; b++) begin
            if (beat_cnt_q == CNT_W'(b)) begin
              for (int unsigned l = 0; l < LANES; l++) begin
                nib_d[(b*LANES + l)*4 +: 4] = prod_data[l*SUM_W + SHIFT +: 4];
              end
            end
          end
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
            state_d = EMIT;
          end
        end
      end

      EMIT: begin
        if (!out_full) begin
          out_we_d    = 1'b1;
          out_data_d  = nib_q ^ hash_q;
          words_out_d = words_out_q + 32'd1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      hash_q      <= '0;
      nib_q       <= '0;
      out_we_q    <= 1'b0;
      out_data_q  <= '0;
      words_out_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      hash_q      <= hash_d;
      nib_q       <= nib_d;
      out_we_q    <= out_we_d;
      out_data_q  <= out_data_d;
      words_out_q <= words_out_d;
    end
  end

  assign out_we    = out_we_q;
  assign out_data  = out_data_q;
  assign words_out = words_out_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_heavyhash_xor_packer.sv
// Directed self-checking bench for heavyhash_xor_packer.
module tb_heavyhash_xor_packer;

  localparam int unsigned LANES  = 16;
  localparam int unsigned SUM_W  = 14;
  localparam int unsigned HASH_W = 256;
  localparam int unsigned PW     = LANES * SUM_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              hash_in_valid = 1'b0;
  logic [HASH_W-1:0] hash_in_data = '0;
  logic              hash_in_ready;
  logic              prod_valid = 1'b0;
  logic [PW-1:0]     prod_data = '0;
  logic              prod_ready;
  logic              out_full = 1'b0;
  logic              out_we;
  logic [HASH_W-1:0] out_data;
  logic              busy;
  logic [31:0]       words_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_words = 32'd0;

  heavyhash_xor_packer #(
    .LANES (LANES),
    .SUM_W (SUM_W),
    .SHIFT (10),
    .HASH_W(HASH_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .hash_in_valid(hash_in_valid),
    .hash_in_data (hash_in_data),
    .hash_in_ready(hash_in_ready),
    .prod_valid   (prod_valid),
    .prod_data    (prod_data),
    .prod_ready   (prod_ready),
    .out_full     (out_full),
    .out_we       (out_we),
    .out_data     (out_data),
    .busy         (busy),
    .words_out    (words_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [PW-1:0] uni(input logic [SUM_W-1:0] s);
    uni = {LANES{s}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_hash(input logic [HASH_W-1:0] h);
    logic ok;
    ok = 1'b0;
    hash_in_valid = 1'b1;
    hash_in_data  = h;
    for (int i = 0; i < 50; i++) begin
      ok = hash_in_ready;
      tick();
      if (ok) break;
    end
    hash_in_valid = 1'b0;
    if (!ok) begin
      errors++;
      $display("FAIL send_hash: hash_in_ready never seen (got %0b, want 1)", ok);
    end
  endtask

  task automatic send_beat(input logic [PW-1:0] d);
    logic ok;
    ok = 1'b0;
    prod_valid = 1'b1;
    prod_data  = d;
    for (int i = 0; i < 50; i++) begin
      ok = prod_ready;
      tick();
      if (ok) break;
    end
    prod_valid = 1'b0;
    if (!ok) begin
      errors++;
      $display("FAIL send_beat: prod_ready never seen (got %0b, want 1)", ok);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if (out_we !== 1'b0 || out_data !== '0 || words_out !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: we=%0b data=%h words=%0d busy=%0b want all 0",
               out_we, out_data, words_out, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++;
    if (hash_in_ready !== 1'b1 || prod_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_readies: hash_rdy=%0b prod_rdy=%0b want 1/0", hash_in_ready, prod_ready);
    end
  endtask

  task automatic test_basic();
    send_hash('0);
    for (int b = 0; b < 4; b++) send_beat(uni(14'h0400));
    exp_words++;
    checks++;
    if (out_we !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_early: we=%0b busy=%0b want 0/1", out_we, busy);
    end
    tick();
    checks++;
    if (out_we !== 1'b1) begin
      errors++;
      $display("FAIL basic_we: got %0b want 1", out_we);
    end
    checks++;
    if (out_data !== {64{4'h1}}) begin
      errors++;
      $display("FAIL basic_data: got %h want %h", out_data, {64{4'h1}});
    end
    checks++;
    if (words_out !== exp_words) begin
      errors++;
      $display("FAIL basic_words: got %0d want %0d", words_out, exp_words);
    end
    tick();
    checks++;
    if (out_we !== 1'b0 || out_data !== {64{4'h1}} || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse: we=%0b data=%h busy=%0b want 0/held/0", out_we, out_data, busy);
    end
  endtask

  task automatic test_reset_mid_collect();
    logic [HASH_W-1:0] exp;
    send_hash({8{32'hA5A5_5A5A}});
    send_beat(uni(14'h3C00));
    send_beat(uni(14'h3C00));
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_we !== 1'b0 || out_data !== '0 || words_out !== 32'd0 ||
        busy !== 1'b0 || prod_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: we=%0b data=%h words=%0d busy=%0b prod_rdy=%0b want all 0",
               out_we, out_data, words_out, busy, prod_ready);
    end
    exp_words = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    send_hash('0);
    for (int b = 0; b < 4; b++) begin
      logic [PW-1:0] v;
      for (int l = 0; l < 16; l++) v[l*SUM_W +: SUM_W] = 14'(((b*16 + l) % 16) << 10);
      send_beat(v);
    end
    exp = {4{64'hFEDC_BA98_7654_3210}};
    exp_words++;
    tick();
    checks++;
    if (out_we !== 1'b1 || out_data !== exp) begin
      errors++;
      $display("FAIL midreset_result: we=%0b data=%h want 1/%h", out_we, out_data, exp);
    end
    checks++;
    if (words_out !== exp_words) begin
      errors++;
      $display("FAIL midreset_words: got %0d want %0d", words_out, exp_words);
    end
    tick();
  endtask

  task automatic test_xor_boundary();
    logic [PW-1:0]     v;
    logic [HASH_W-1:0] exp;
    send_hash('1);
    for (int b = 0; b < 3; b++) send_beat(uni(14'h3C00));
    v = uni(14'h3C00);
    v[13:0]  = 14'h3FFF;
    v[27:14] = 14'h03FF;
    send_beat(v);
    exp = '0;
    exp[49*4 +: 4] = 4'hF;
    exp_words++;
    tick();
    checks++;
    if (out_we !== 1'b1 || out_data !== exp) begin
      errors++;
      $display("FAIL xor_boundary: we=%0b data=%h want 1/%h", out_we, out_data, exp);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [HASH_W-1:0] exp;
    int bad;
    bad = 0;
    exp = {8{32'hFC8F_9CCD}};
    send_hash({8{32'hDEAD_BEEF}});
    out_full = 1'b1;
    for (int b = 0; b < 4; b++) send_beat(uni(14'h0800));
    prod_valid    = 1'b1;
    prod_data     = uni(14'h3C00);
    hash_in_valid = 1'b1;
    hash_in_data  = '1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_we !== 1'b0 || prod_ready !== 1'b0 || hash_in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL full_hold[%0d]: we=%0b prod_rdy=%0b hash_rdy=%0b busy=%0b want 0/0/0/1",
                 i, out_we, prod_ready, hash_in_ready, busy);
      end
      tick();
    end
    prod_valid    = 1'b0;
    hash_in_valid = 1'b0;
    out_full      = 1'b0;
    exp_words++;
    tick();
    checks++;
    if (out_we !== 1'b1 || out_data !== exp || words_out !== exp_words) begin
      errors++;
      $display("FAIL full_release: we=%0b data=%h words=%0d want 1/%h/%0d",
               out_we, out_data, words_out, exp, exp_words);
    end
    tick();
    checks++;
    if (out_we !== 1'b0 || out_data !== exp || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_after: we=%0b data=%h busy=%0b want 0/%h/0", out_we, out_data, busy, exp);
    end
  endtask

  task automatic test_gaps();
    bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [HASH_W-1:0] exp;
    int b;
    int writes;
    b = 0;
    writes = 0;
    exp = {{16{4'h6}}, {16{4'h5}}, {16{4'h4}}, {16{4'h3}}};
    send_hash('0);
    for (int i = 0; i < 7; i++) begin
      prod_valid = pat[i];
      prod_data  = pat[i] ? uni(14'((b + 3) << 10)) : uni(14'h3C00);
      checks++;
      if (prod_ready !== 1'b1 || out_we !== 1'b0) begin
        errors++;
        $display("FAIL gaps_collect[%0d]: prod_rdy=%0b we=%0b want 1/0", i, prod_ready, out_we);
      end
      if (pat[i]) b++;
      tick();
    end
    prod_valid = 1'b0;
    checks++;
    if (prod_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL gaps_emit: prod_rdy=%0b busy=%0b want 0/1", prod_ready, busy);
    end
    exp_words++;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_we === 1'b1) begin
        writes++;
        checks++;
        if (out_data !== exp) begin
          errors++;
          $display("FAIL gaps_data: got %h want %h", out_data, exp);
        end
      end
    end
    checks++;
    if (writes != 1) begin
      errors++;
      $display("FAIL gaps_writes: got %0d want 1", writes);
    end
  endtask

  task automatic test_back_to_back();
    logic [HASH_W-1:0] hs[3];
    logic [HASH_W-1:0] exp;
    int wcyc[3];
    int cyc, nw, kh, nb;
    logic hacc, pacc;
    hs[0] = {8{32'h0123_4567}};
    hs[1] = {8{32'h89AB_CDEF}};
    hs[2] = '0;
    cyc = 0; nw = 0; kh = 0; nb = 0;
    hash_in_valid = 1'b1;
    hash_in_data  = hs[0];
    prod_valid    = 1'b1;
    prod_data     = uni(14'h0400);
    while (nw < 3 && cyc < 60) begin
      hacc = hash_in_valid & hash_in_ready;
      pacc = prod_valid & prod_ready;
      tick();
      cyc++;
      if (hacc) kh++;
      if (pacc) nb++;
      hash_in_valid = (kh < 3);
      hash_in_data  = (kh < 3) ? hs[kh] : '0;
      prod_valid    = (nb < 12);
      prod_data     = uni(14'(((nb / 4) + 1) << 10));
      if (out_we === 1'b1) begin
        exp = hs[nw] ^ {64{4'(nw + 1)}};
        exp_words++;
        checks++;
        if (out_data !== exp) begin
          errors++;
          $display("FAIL b2b_data[%0d]: got %h want %h", nw, out_data, exp);
        end
        wcyc[nw] = cyc;
        nw++;
      end
    end
    hash_in_valid = 1'b0;
    prod_valid    = 1'b0;
    checks++;
    if (nw != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d writes want 3", nw);
    end else begin
      checks++;
      if (wcyc[1] - wcyc[0] != 6 || wcyc[2] - wcyc[1] != 6) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d,%0d want 6,6", wcyc[1] - wcyc[0], wcyc[2] - wcyc[1]);
      end
    end
    checks++;
    if (words_out !== exp_words) begin
      errors++;
      $display("FAIL b2b_words: got %0d want %0d", words_out, exp_words);
    end
    tick();
  endtask

  task automatic test_wrap();
    dut.words_out_q = 32'hFFFF_FFFF;
    tick();
    send_hash('0);
    for (int b = 0; b < 4; b++) send_beat(uni(14'h0400));
    tick();
    checks++;
    if (out_we !== 1'b1 || words_out !== 32'd0) begin
      errors++;
      $display("FAIL wrap_words: we=%0b words=%h want 1/00000000", out_we, words_out);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_mid_collect();
    test_xor_boundary();
    test_backpressure();
    test_gaps();
    test_back_to_back();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
